// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: format decode, one output register and a skid buffer.
// Optional `IMMGEN_ERR_CNT_EN adds an 8-bit saturating count of accepted illegal selects.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [24:0]       in_instr,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_err
`ifdef IMMGEN_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (SEL_W != 3) begin : g_bad_sel
      $fatal(1, "imm_gen_pipe: SEL_W must be 3");
    end
  endgenerate

  // in_instr[k] is instruction bit k+7, so instruction bit 31 is ins[24].
  function automatic logic [XLEN-1:0] ext_imm(input logic [24:0] ins,
                                              input logic [SEL_W-1:0] sel);
    logic signed [31:0]     s32;
    logic signed [XLEN-1:0] sx;
    logic [XLEN-1:0]        res;
    logic                   use_sx;
    s32    = '0;
    res    = '0;
    use_sx = 1'b0;
    case (sel)
      3'b000: begin s32 = {{20{ins[24]}}, ins[24:13]}; use_sx = 1'b1; end
      3'b001: begin s32 = {{20{ins[24]}}, ins[24:18], ins[4:0]}; use_sx = 1'b1; end
      3'b010: begin s32 = {{20{ins[24]}}, ins[0], ins[23:18], ins[4:1], 1'b0}; use_sx = 1'b1; end
      3'b011: begin s32 = {{12{ins[24]}}, ins[12:5], ins[13], ins[23:14], 1'b0}; use_sx = 1'b1; end
      3'b100: begin s32 = {ins[24:5], 12'b0}; use_sx = 1'b1; end
      3'b101: begin
        res[4:0] = ins[17:13];
        if (XLEN == 64) res[5] = ins[18];
      end
      3'b110: res[4:0] = ins[12:8];
      default: res = '0;
    endcase
    sx = s32;
    if (use_sx) res = sx;
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic            main_vld_q, main_vld_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic            main_err_q, main_err_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            skid_err_q, skid_err_d;
  logic            in_xfer, out_xfer;
  logic [XLEN-1:0] new_imm;
  logic            new_err;

  assign in_xfer  = in_valid & ~skid_vld_q;
  assign out_xfer = main_vld_q & out_ready;
  assign new_imm  = ext_imm(in_instr, in_sel);
  assign new_err  = (in_sel == 3'b111);

  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_err_d = main_err_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_err_d = skid_err_q;
    if (!main_vld_q || out_xfer) begin
      // Skid full implies in_ready was low, so no new input competes for main here.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_imm_d = skid_imm_q;
        main_err_d = skid_err_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_xfer;
        if (in_xfer) begin
          main_imm_d = new_imm;
          main_err_d = new_err;
        end
      end
    end else if (in_xfer) begin
      skid_vld_d = 1'b1;
      skid_imm_d = new_imm;
      skid_err_d = new_err;
    end
  end

  // Output / skid register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_err_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_err_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_err_q <= main_err_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_err_q <= skid_err_d;
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_imm   = main_imm_q;
  assign out_err   = main_err_q;

`ifdef IMMGEN_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign err_cnt_d = (in_xfer && new_err) ? sat_inc(err_cnt_q) : err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the stimulus.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic        clk, rst_n, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_sel;
  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
`ifdef IMMGEN_ERR_CNT_EN
  logic [7:0]  err_cnt32, err_cnt64;
`endif

  logic [31:0] exp32;
  logic [63:0] exp64;
  logic        exp_err;
  exp_t        q32[$], q64[$];
  int          pass_cnt = 0, total_cnt = 0;
  int          n_out32 = 0, n_out64 = 0;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_sel(in_sel), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_err(out_err32)
`ifdef IMMGEN_ERR_CNT_EN
    , .err_cnt(err_cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_sel(in_sel), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_err(out_err64)
`ifdef IMMGEN_ERR_CNT_EN
    , .err_cnt(err_cnt64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Monitor: pop the oldest expectation on each output transfer, then record new acceptances.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid32 && out_ready) begin
      if (q32.size() == 0) check("unexpected_out32", 64'(out_imm32), 64'hDEAD);
      else begin
        e = q32.pop_front();
        check("imm32", 64'(out_imm32), e.imm);
        check("err32", 64'(out_err32), 64'(e.err));
      end
      n_out32++;
    end
    if (out_valid64 && out_ready) begin
      if (q64.size() == 0) check("unexpected_out64", out_imm64, 64'hDEAD);
      else begin
        e = q64.pop_front();
        check("imm64", out_imm64, e.imm);
        check("err64", 64'(out_err64), 64'(e.err));
      end
      n_out64++;
    end
    if (rst_n && in_valid && in_ready32) q32.push_back('{imm: 64'(exp32), err: exp_err});
    if (rst_n && in_valid && in_ready64) q64.push_back('{imm: exp64, err: exp_err});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [2:0] sel,
                      input logic [31:0] e32, input logic [63:0] e64, input logic eerr);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_instr = ins[31:7];
    in_sel   = sel;
    exp32    = e32;
    exp64    = e64;
    exp_err  = eerr;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready32;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  int n0;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; in_sel = '0; out_ready = 1'b1;
    exp32 = '0; exp64 = '0; exp_err = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_in_ready32", 64'(in_ready32), 64'd1);
    check("rst_out_imm32", 64'(out_imm32), 64'd0);
    check("rst_out_err32", 64'(out_err32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_out_imm64", out_imm64, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Single I-type, latency one edge
    send(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    check("lat1_out_valid32", 64'(out_valid32), 64'd1);
    check("in_ready_stays", 64'(in_ready32), 64'd1);
    idle(2);

    // Back-to-back S, B, U with ready high
    n0 = n_out32;
    send(32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'hFE000CE3, 3'b010, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    send(32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0);
    check("b2b_two_out", 64'(n_out32), 64'(n0 + 2));
    @(negedge clk); #1;
    check("b2b_three_out", 64'(n_out32), 64'(n0 + 3));
    idle(1);

    // Remaining formats and boundaries
    send(32'h03F00093, 3'b101, 32'h0000001F, 64'h000000000000003F, 1'b0);
    send(32'h000F8073, 3'b110, 32'h0000001F, 64'h000000000000001F, 1'b0);
    send(32'hDEADBEEF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1);
    send(32'hFFDFF0EF, 3'b011, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    send(32'h008000EF, 3'b011, 32'h00000008, 64'h0000000000000008, 1'b0);
    idle(3);

    // Back-pressure: two accepted, third held off
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'hFE112E23, 3'b001, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    check("bp_in_ready32", 64'(in_ready32), 64'd0);
    check("bp_in_ready64", 64'(in_ready64), 64'd0);
    in_valid = 1'b1; in_instr = 25'(32'h123450B7 >> 7); in_sel = 3'b100;
    exp32 = 32'h12345000; exp64 = 64'h0000000012345000; exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 64'(in_ready32), 64'd0);
      check("bp_hold_valid", 64'(out_valid32), 64'd1);
      check("bp_hold_imm32", 64'(out_imm32), 64'hFFFFFFFF);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0);
    idle(4);
    check("bp_drained32", 64'(q32.size()), 64'd0);

    // Reset with both registers full
    out_ready = 1'b0;
    send(32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    send(32'hFE000CE3, 3'b010, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    #2 rst_n = 1'b0;
    q32.delete();
    q64.delete();
    #1;
    check("mid_rst_out_valid", 64'(out_valid32), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready32), 64'd1);
    check("mid_rst_out_imm", 64'(out_imm32), 64'd0);
    check("mid_rst_out_valid64", 64'(out_valid64), 64'd0);
`ifdef IMMGEN_ERR_CNT_EN
    check("rst_err_cnt", 64'(err_cnt32), 64'd0);
`endif
    @(negedge clk); #2 rst_n = 1'b1;
    idle(1);
    n0 = n_out32;
    out_ready = 1'b1;
    send(32'h123450B7, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0);
    idle(4);
    check("post_rst_alone", 64'(n_out32), 64'(n0 + 1));

`ifdef IMMGEN_ERR_CNT_EN
    for (int i = 0; i < 300; i++)
      send($urandom, 3'b111, 32'h0, 64'h0, 1'b1);
    idle(3);
    check("err_cnt32_sat", 64'(err_cnt32), 64'd255);
    check("err_cnt64_sat", 64'(err_cnt64), 64'd255);
`endif

    idle(3);
    check("final_q32_empty", 64'(q32.size()), 64'd0);
    check("final_q64_empty", 64'(q64.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
